// File: rtl/branch_predictor_if.sv
// Fetch/update/statistics bundle for the 2-wide fetch branch predictor.
// master: fetch and execute side (drives PCs and resolved outcomes).
// slave : the predictor itself.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken0;
  logic [31:0] pred_target0;
  logic        pred_taken1;
  logic [31:0] pred_target1;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] cnt_branches;
  logic [31:0] cnt_mispred;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_br, upd_is_jump,
           upd_taken, upd_target, upd_mispred,
    input  pred_taken0, pred_target0, pred_taken1, pred_target1,
           pred_next_pc, cnt_branches, cnt_mispred
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_br, upd_is_jump,
           upd_taken, upd_target, upd_mispred,
    output pred_taken0, pred_target0, pred_taken1, pred_target1,
           pred_next_pc, cnt_branches, cnt_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor for a 2-wide fetch pair (pc, pc+4).
// Direct-mapped BTB (valid/tag/target) plus 2-bit saturating counters,
// trained from the execute-stage update port. Lookup is combinational
// from registered state; a same-cycle update is not bypassed.
// Optional: define BPRED_GSHARE_EN to XOR a non-speculative global
// history register into the counter index (BTB stays PC-indexed).
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned TAG_BITS = 30 - IDX_BITS,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [31:0]         cnt_br_q;
  logic [31:0]         cnt_mis_q;

`ifdef BPRED_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;
`endif

  logic [31:0]         pc1;
  logic [31:0]         pc2;
  logic [IDX_BITS-1:0] bidx0, bidx1, cidx0, cidx1;
  logic [IDX_BITS-1:0] upd_bidx, upd_cidx;
  logic [TAG_BITS-1:0] tag0, tag1, upd_tag;
  logic                hit0, hit1, taken0, taken1;
  logic                btb_we, cnt_we;
  logic [1:0]          cnt_cur, cnt_nxt;
  logic                unused_pc_lsbs;

  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  // Slot PCs, table indices and tags for lookup and update
  always_comb begin
    pc1      = bus.fetch_pc + 32'd4;
    pc2      = bus.fetch_pc + 32'd8;
    bidx0    = bus.fetch_pc[IDX_BITS+1:2];
    tag0     = bus.fetch_pc[31:IDX_BITS+2];
    bidx1    = pc1[IDX_BITS+1:2];
    tag1     = pc1[31:IDX_BITS+2];
    upd_bidx = bus.upd_pc[IDX_BITS+1:2];
    upd_tag  = bus.upd_pc[31:IDX_BITS+2];
`ifdef BPRED_GSHARE_EN
    cidx0    = bidx0 ^ ghr_q;
    cidx1    = bidx1 ^ ghr_q;
    upd_cidx = upd_bidx ^ ghr_q;
`else
    cidx0    = bidx0;
    cidx1    = bidx1;
    upd_cidx = upd_bidx;
`endif
  end

  // Prediction for both slots; slot 1 is suppressed when slot 0 redirects
  always_comb begin
    hit0 = valid_q[bidx0] && (tag_q[bidx0] == tag0);
    hit1 = valid_q[bidx1] && (tag_q[bidx1] == tag1);
    taken0 = hit0 && cnt_q[cidx0][1];
    taken1 = hit1 && cnt_q[cidx1][1] && !taken0;
    bus.pred_taken0  = taken0;
    bus.pred_taken1  = taken1;
    bus.pred_target0 = taken0 ? target_q[bidx0] : pc1;
    bus.pred_target1 = taken1 ? target_q[bidx1] : pc2;
    if (taken0)      bus.pred_next_pc = target_q[bidx0];
    else if (taken1) bus.pred_next_pc = target_q[bidx1];
    else             bus.pred_next_pc = pc2;
    bus.cnt_branches = cnt_br_q;
    bus.cnt_mispred  = cnt_mis_q;
  end

  // Training decision: BTB allocation and next counter value
  always_comb begin
    cnt_cur = cnt_q[upd_cidx];
    btb_we  = bus.upd_valid && (bus.upd_is_jump || (bus.upd_is_br && bus.upd_taken));
    cnt_we  = bus.upd_valid && (bus.upd_is_jump || bus.upd_is_br);
    if (bus.upd_is_jump)    cnt_nxt = 2'b11;
    else if (bus.upd_taken) cnt_nxt = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'd1;
    else                    cnt_nxt = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'd1;
  end

  // Valid bits and direction counters (reset-initialised state)
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      if (btb_we) valid_q[upd_bidx] <= 1'b1;
      if (cnt_we) cnt_q[upd_cidx]   <= cnt_nxt;
    end
  end

  // Tag and target storage; no reset needed since valid gates every hit
  always_ff @(posedge clk) begin
    if (!rst && btb_we) begin
      tag_q[upd_bidx]    <= upd_tag;
      target_q[upd_bidx] <= bus.upd_target;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else if (bus.upd_valid) begin
      if (cnt_br_q != '1)                      cnt_br_q  <= cnt_br_q + 32'd1;
      if (bus.upd_mispred && (cnt_mis_q != '1)) cnt_mis_q <= cnt_mis_q + 32'd1;
    end
  end

`ifdef BPRED_GSHARE_EN
  // Global history of resolved conditional branches; counters index with the pre-shift value
  always_ff @(posedge clk) begin
    if (rst)                                 ghr_q <= '0;
    else if (bus.upd_valid && bus.upd_is_br) ghr_q <= {ghr_q[IDX_BITS-2:0], bus.upd_taken};
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run compared against a table-level behavioural model.
module tb_branch_predictor;

  logic clk;
  logic rst;
  branch_predictor_if bus ();

  branch_predictor #(.IDX_BITS(6), .TAG_BITS(24), .CNT_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: 64 entries, counters kept as plain integers 0..3
  localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;
  bit          m_valid [64];
  bit [31:0]   m_tag   [64];
  bit [31:0]   m_tgt   [64];
  int          m_cnt   [64];
  bit [5:0]    m_ghr;
  longint unsigned m_nbr, m_nmis;

  function automatic int bidx_of(bit [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int cidx_of(bit [31:0] pc);
`ifdef BPRED_GSHARE_EN
    return bidx_of(pc) ^ int'(m_ghr);
`else
    return bidx_of(pc);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_ghr = '0; m_nbr = 0; m_nmis = 0;
  endtask

  task automatic model_predict(input bit [31:0] pc, output bit tk0, output bit [31:0] tg0,
                               output bit tk1, output bit [31:0] tg1, output bit [31:0] nxt);
    bit [31:0] pcb = pc + 32'd4;
    int i0 = bidx_of(pc);
    int i1 = bidx_of(pcb);
    bit h0 = m_valid[i0] && (m_tag[i0] == (pc >> 8));
    bit h1 = m_valid[i1] && (m_tag[i1] == (pcb >> 8));
    tk0 = h0 && (m_cnt[cidx_of(pc)] >= 2);
    tk1 = !tk0 && h1 && (m_cnt[cidx_of(pcb)] >= 2);
    tg0 = tk0 ? m_tgt[i0] : pc + 32'd4;
    tg1 = tk1 ? m_tgt[i1] : pc + 32'd8;
    nxt = tk0 ? tg0 : (tk1 ? tg1 : pc + 32'd8);
  endtask

  task automatic model_update(input bit v, input bit [31:0] pc, input bit isbr, input bit isj,
                              input bit tk, input bit [31:0] tgt, input bit mis);
    int bi = bidx_of(pc);
    int ci = cidx_of(pc);
    if (!v) return;
    if (m_nbr < CMAX) m_nbr++;
    if (mis && m_nmis < CMAX) m_nmis++;
    if (isbr) begin
      if (tk) begin
        m_cnt[ci] = (m_cnt[ci] + 1 > 3) ? 3 : m_cnt[ci] + 1;
        m_valid[bi] = 1'b1; m_tag[bi] = pc >> 8; m_tgt[bi] = tgt;
      end else begin
        m_cnt[ci] = (m_cnt[ci] - 1 < 0) ? 0 : m_cnt[ci] - 1;
      end
      m_ghr = {m_ghr[4:0], tk};
    end else if (isj) begin
      m_cnt[ci] = 3;
      m_valid[bi] = 1'b1; m_tag[bi] = pc >> 8; m_tgt[bi] = tgt;
    end
  endtask

  // One clock: the model absorbs whatever the DUT sees on this edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_update(bus.upd_valid, bus.upd_pc, bus.upd_is_br, bus.upd_is_jump,
                      bus.upd_taken, bus.upd_target, bus.upd_mispred);
    @(negedge clk);
  endtask

  task automatic set_upd(input bit v, input bit [31:0] pc, input bit isbr, input bit isj,
                         input bit tk, input bit [31:0] tgt, input bit mis);
    bus.upd_valid = v; bus.upd_pc = pc; bus.upd_is_br = isbr; bus.upd_is_jump = isj;
    bus.upd_taken = tk; bus.upd_target = tgt; bus.upd_mispred = mis;
  endtask

  task automatic idle_upd();
    set_upd(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1);  // must be dropped
    tick(); tick();
    rst = 1'b0; idle_upd();
    bus.fetch_pc = 32'h0000_0100; #1;
    n_total++; if (bus.pred_taken0 !== 1'b0) $display("FAIL reset_taken0: got %b expected 0", bus.pred_taken0); else n_pass++;
    n_total++; if (bus.pred_taken1 !== 1'b0) $display("FAIL reset_taken1: got %b expected 0", bus.pred_taken1); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h108) $display("FAIL reset_next_pc: got %h expected 00000108", bus.pred_next_pc); else n_pass++;
    n_total++; if (bus.cnt_branches !== 32'd0) $display("FAIL reset_cnt_branches: got %0d expected 0", bus.cnt_branches); else n_pass++;
    n_total++; if (bus.cnt_mispred !== 32'd0) $display("FAIL reset_cnt_mispred: got %0d expected 0", bus.cnt_mispred); else n_pass++;
    bus.fetch_pc = 32'hFFFF_FFFC; #1;
    n_total++; if (bus.pred_next_pc !== 32'h4) $display("FAIL wrap_next_pc: got %h expected 00000004", bus.pred_next_pc); else n_pass++;
    n_total++; if (bus.pred_target0 !== 32'h0) $display("FAIL wrap_target0: got %h expected 00000000", bus.pred_target0); else n_pass++;
    n_total++; if (bus.pred_target1 !== 32'h4) $display("FAIL wrap_target1: got %h expected 00000004", bus.pred_target1); else n_pass++;
  endtask

  task automatic test_jump_slot1();
    set_upd(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
    tick(); idle_upd();
    bus.fetch_pc = 32'h100; #1;
    n_total++; if (bus.pred_taken0 !== 1'b0) $display("FAIL jump_taken0: got %b expected 0", bus.pred_taken0); else n_pass++;
    n_total++; if (bus.pred_taken1 !== 1'b1) $display("FAIL jump_taken1: got %b expected 1", bus.pred_taken1); else n_pass++;
    n_total++; if (bus.pred_target1 !== 32'h400) $display("FAIL jump_target1: got %h expected 00000400", bus.pred_target1); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h400) $display("FAIL jump_next_pc: got %h expected 00000400", bus.pred_next_pc); else n_pass++;
  endtask

  task automatic test_taken_branch();
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    tick(); idle_upd();
    bus.fetch_pc = 32'h100; #1;
    n_total++; if (bus.pred_taken0 !== 1'b1) $display("FAIL br_taken0: got %b expected 1", bus.pred_taken0); else n_pass++;
    n_total++; if (bus.pred_target0 !== 32'h200) $display("FAIL br_target0: got %h expected 00000200", bus.pred_target0); else n_pass++;
    n_total++; if (bus.pred_taken1 !== 1'b0) $display("FAIL mask_taken1: got %b expected 0", bus.pred_taken1); else n_pass++;
    n_total++; if (bus.pred_target1 !== 32'h108) $display("FAIL mask_target1: got %h expected 00000108", bus.pred_target1); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h200) $display("FAIL br_next_pc: got %h expected 00000200", bus.pred_next_pc); else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); tick();
    end
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick(); idle_upd();
    bus.fetch_pc = 32'h100; #1;
    n_total++; if (bus.pred_taken0 !== 1'b1) $display("FAIL sat_hi_taken0: got %b expected 1", bus.pred_taken0); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h200) $display("FAIL sat_hi_next_pc: got %h expected 00000200", bus.pred_next_pc); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); tick();
    end
    idle_upd(); #1;
    n_total++; if (bus.pred_taken0 !== 1'b0) $display("FAIL sat_lo_taken0: got %b expected 0", bus.pred_taken0); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h400) $display("FAIL sat_lo_next_pc: got %h expected 00000400", bus.pred_next_pc); else n_pass++;
    n_total++; if (dut.valid_q[0] !== 1'b1) $display("FAIL sat_lo_valid: got %b expected 1", dut.valid_q[0]); else n_pass++;
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 2; i++) begin
      set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0); tick();
    end
    bus.fetch_pc = 32'h100;
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0); #1;
    n_total++; if (bus.pred_target0 !== 32'h200) $display("FAIL same_cycle_old_target: got %h expected 00000200", bus.pred_target0); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h200) $display("FAIL same_cycle_old_next: got %h expected 00000200", bus.pred_next_pc); else n_pass++;
    tick(); idle_upd(); #1;
    n_total++; if (bus.pred_target0 !== 32'h300) $display("FAIL same_cycle_new_target: got %h expected 00000300", bus.pred_target0); else n_pass++;
    n_total++; if (bus.pred_next_pc !== 32'h300) $display("FAIL same_cycle_new_next: got %h expected 00000300", bus.pred_next_pc); else n_pass++;
  endtask

  task automatic test_perf_counters();
    bit mis [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; idle_upd(); tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0, mis[i]); tick();
    end
    idle_upd(); #1;
    n_total++; if (bus.cnt_branches !== 32'd4) $display("FAIL perf_branches: got %0d expected 4", bus.cnt_branches); else n_pass++;
    n_total++; if (bus.cnt_mispred !== 32'd3) $display("FAIL perf_mispred: got %0d expected 3", bus.cnt_mispred); else n_pass++;
    force dut.cnt_br_q  = 32'hFFFF_FFFF;
    force dut.cnt_mis_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_br_q;
    release dut.cnt_mis_q;
    m_nbr = CMAX; m_nmis = CMAX;
    set_upd(1'b1, 32'h180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick(); idle_upd(); #1;
    n_total++; if (bus.cnt_branches !== 32'hFFFF_FFFF) $display("FAIL perf_branches_sat: got %h expected ffffffff", bus.cnt_branches); else n_pass++;
    n_total++; if (bus.cnt_mispred !== 32'hFFFF_FFFF) $display("FAIL perf_mispred_sat: got %h expected ffffffff", bus.cnt_mispred); else n_pass++;
  endtask

  function automatic bit [31:0] pool_pc();
    int k = int'($urandom_range(0, 17));
    bit [31:0] r;
    if (k < 8)   return 32'h100 + 32'(4 * k);
    if (k < 16)  return 32'h1100 + 32'(4 * (k - 8));
    if (k == 16) return 32'hFFFF_FFFC;
    r = $urandom;
    return {r[31:2], 2'b00};
  endfunction

  task automatic test_random();
    bit tk0, tk1;
    bit [31:0] tg0, tg1, nxt, tgt;
    int kind;
    rst = 1'b1; idle_upd(); tick(); rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.fetch_pc = pool_pc();
      kind = int'($urandom_range(0, 9));
      tgt = $urandom; tgt[1:0] = 2'b00;
      set_upd(kind < 8, pool_pc(), kind < 5, kind == 5 || kind == 6,
              $urandom_range(0, 1) == 1, tgt, $urandom_range(0, 3) == 0);
      #1;
      model_predict(bus.fetch_pc, tk0, tg0, tk1, tg1, nxt);
      n_total++; if (bus.pred_taken0 !== tk0) $display("FAIL rnd_taken0 pc=%h: got %b expected %b", bus.fetch_pc, bus.pred_taken0, tk0); else n_pass++;
      n_total++; if (bus.pred_target0 !== tg0) $display("FAIL rnd_target0 pc=%h: got %h expected %h", bus.fetch_pc, bus.pred_target0, tg0); else n_pass++;
      n_total++; if (bus.pred_taken1 !== tk1) $display("FAIL rnd_taken1 pc=%h: got %b expected %b", bus.fetch_pc, bus.pred_taken1, tk1); else n_pass++;
      n_total++; if (bus.pred_target1 !== tg1) $display("FAIL rnd_target1 pc=%h: got %h expected %h", bus.fetch_pc, bus.pred_target1, tg1); else n_pass++;
      n_total++; if (bus.pred_next_pc !== nxt) $display("FAIL rnd_next_pc pc=%h: got %h expected %h", bus.fetch_pc, bus.pred_next_pc, nxt); else n_pass++;
      n_total++; if (bus.cnt_branches !== 32'(m_nbr)) $display("FAIL rnd_cnt_branches: got %0d expected %0d", bus.cnt_branches, m_nbr); else n_pass++;
      n_total++; if (bus.cnt_mispred !== 32'(m_nmis)) $display("FAIL rnd_cnt_mispred: got %0d expected %0d", bus.cnt_mispred, m_nmis); else n_pass++;
      tick();
    end
    rst = 1'b0; idle_upd();
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_pc = '0;
    idle_upd();
    model_reset();
    @(negedge clk);
    test_reset();
    test_jump_slot1();
`ifndef BPRED_GSHARE_EN
    test_taken_branch();
    test_saturation();
    test_same_cycle();
`endif
    test_perf_counters();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor for the 2-wide superscalar pipeline.
- Each cycle it predicts direction and target for the fetch pair at pc and pc+4 and produces the next fetch PC.
- The execute stage resolves each branch or jump and reports the outcome on the update port, which trains the tables.
- Combines a direct-mapped BTB (valid, tag, target) with a table of 2-bit saturating counters.

Parameters:
IDX_BITS, 6, log2 of table entries (64 entries); index = pc[IDX_BITS+1:2]
TAG_BITS, 30-IDX_BITS, tag = pc[31:IDX_BITS+2]
CNT_INIT, 2'b01, counter value after reset (weakly not-taken)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
fetch_pc  input  32  PC of slot 0; slot 1 is fetch_pc+4
pred_taken0  output  1  slot 0 predicted taken
pred_target0  output  32  slot 0 predicted target (fetch_pc+4 when not taken)
pred_taken1  output  1  slot 1 predicted taken (forced 0 if pred_taken0)
pred_target1  output  32  slot 1 predicted target (fetch_pc+8 when not taken)
pred_next_pc  output  32  next fetch PC
upd_valid  input  1  resolved control-transfer instruction this cycle
upd_pc  input  32  PC of resolved instruction
upd_is_br  input  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
upd_is_jump  input  1  JAL/JALR
upd_taken  input  1  resolved direction
upd_target  input  32  resolved target
upd_mispred  input  1  execute detected misprediction
cnt_branches  output  32  resolved updates counted
cnt_mispred  output  32  mispredictions counted

Behaviour:
- Lookup is combinational from registered tables, zero latency: hitN = valid[idx] & tag[idx]==tagN.
- pred_takenN = hitN & cnt[idx][1].
- pred_next_pc = target0 if pred_taken0; else target1 if pred_taken1; else fetch_pc+8.
- Slot 1 is predicted independently but pred_taken1 is masked to 0 when pred_taken0=1.
- If fetch_pc and fetch_pc+4 map to the same index (IDX_BITS=0 only), both slots read the same entry. No special handling.
- Updates are written on the clock edge when upd_valid=1. upd_is_br and upd_is_jump are never both 1. If neither is set, no table change, but the counters still count.
- Conditional branch, taken: counter +1 saturating at 3; BTB entry written (valid=1, tag, target=upd_target).
- Conditional branch, not taken: counter -1 saturating at 0; BTB entry not allocated or changed.
- Jump: BTB entry written; counter forced to 2'b11.
- Counter update operates regardless of BTB hit, so aliasing PCs share counters.
- An update and a lookup to the same index in the same cycle: the lookup sees the pre-update value (no bypass).
- Performance counters:
  - cnt_branches increments on every upd_valid.
  - cnt_mispred increments on upd_valid & upd_mispred.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Reset:
  - All valid bits cleared to 0 and all counters set to CNT_INIT; cnt_branches and cnt_mispred cleared to 0.
  - Tag and target storage need no reset.
  - After reset, pred_taken0 = pred_taken1 = 0 and pred_next_pc = fetch_pc+8.
  - Reset has priority over a simultaneous update; that update is dropped.
- PC bits [1:0] are ignored; all arithmetic is 32-bit modulo, so fetch_pc=32'hFFFF_FFFC gives pred_next_pc=32'h0000_0004.

Optional Feature:
- Macro BPRED_GSHARE_EN.
- Defined:
  - Adds an IDX_BITS-wide global history register ghr, reset to 0.
  - On upd_valid & upd_is_br, ghr <= {ghr[IDX_BITS-2:0], upd_taken}. This is non-speculative history.
  - Counter index = pc[IDX_BITS+1:2] ^ ghr, for both lookup and update. The BTB stays PC-indexed.
  - Update uses the ghr value before the same-cycle shift.
- Undefined: no ghr register, and the counter index equals the BTB index.

Test Plan:
- Reset, then fetch_pc=32'h0000_0100 -> pred_taken0=0, pred_taken1=0, pred_next_pc=32'h0000_0108, cnt_branches=0.
- Update pc=32'h100, is_br=1, taken=1, target=32'h200 once; then fetch 32'h100 -> counter 2'b10, pred_taken0=1, pred_next_pc=32'h200.
- Update JAL pc=32'h104, target=32'h400; fetch 32'h100 with slot 0 not predicted taken -> pred_taken1=1, pred_next_pc=32'h400. With slot 0 also predicted taken -> pred_taken1=0, pred_next_pc=slot 0 target.
- Counter saturation: 5 taken updates then 1 not-taken at pc=32'h100 -> counter=2'b10, still predicted taken. 3 further not-taken updates -> counter 2'b00, not taken, BTB valid still 1.
- Same-cycle update (taken, new target 32'h300) and lookup at 32'h100 -> this cycle outputs the old target 32'h200; next cycle outputs 32'h300.
- upd_mispred=1 on 3 of 4 updates -> cnt_branches=4, cnt_mispred=3. With the counter preloaded to 32'hFFFF_FFFF via force, a further update leaves it at 32'hFFFF_FFFF.
